// File: rtl/cpu_ctrl_pkg.sv
// Shared control-word bit positions and memory-stage FSM states for the CPU control slice.
package cpu_ctrl_pkg;

    localparam int unsigned CS_W       = 32;
    localparam int unsigned CS_MAR_PC  = 2;
    localparam int unsigned CS_MAR_MBR = 3;
    localparam int unsigned CS_MEM_RD  = 4;
    localparam int unsigned CS_MEM_WR  = 5;
    localparam int unsigned CS_PC_INC  = 6;
    localparam int unsigned CS_MBR_ACC = 8;
    localparam int unsigned CS_TO_CLR  = 9;
    localparam int unsigned CS_PC_LOAD = 20;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } mem_state_e;

endpackage

// File: rtl/mem_interface_req_timer.sv
// Clearable up-counter that flags when a request has waited TIMEOUT-1 cycles.
module req_timer #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic inc_i,
    output logic tc_o
);

    localparam int unsigned CNT_W = 8;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tc_q;

    // Next count: clear wins over increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register plus terminal-count flag registered from the next count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            tc_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tc_q  <= (cnt_d == CNT_W'(TIMEOUT - 1));
        end
    end

    assign tc_o = tc_q;

endmodule

// File: rtl/mem_interface.sv
// Memory-access stage: MAR/MBR registers and a single-outstanding req/ack transaction FSM.
module mem_interface
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CS_W-1:0]   control_signal,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic [DATA_W-1:0] acc_in,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [ADDR_W-1:0] MAR_out,
    output logic [DATA_W-1:0] MBR_out,
    output logic              busy,
    output logic              timeout_err
);

    mem_state_e        state_q, state_d;
    logic [ADDR_W-1:0] mar_q, mar_d;
    logic [DATA_W-1:0] mbr_q, mbr_d;
    logic              we_q, we_d;
    logic              err_q, err_d;
    logic              req_q;
    logic              tmr_clr, tmr_inc, tmr_tc;
    logic              rd_start, wr_start;

    // Control bits owned by the PC and unused positions are intentionally dropped here.
    logic unused_cs;
    assign unused_cs = ^{control_signal[CS_W-1:10], control_signal[7:6], control_signal[1:0]};

    // Write wins when both start bits are set, so a read only starts without [5].
    assign wr_start = control_signal[CS_MEM_WR];
    assign rd_start = control_signal[CS_MEM_RD] & ~control_signal[CS_MEM_WR];

    req_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_req_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (tmr_clr),
        .inc_i (tmr_inc),
        .tc_o  (tmr_tc)
    );

    // Next-state, register loads and timer control.
    always_comb begin
        state_d = state_q;
        mar_d   = mar_q;
        mbr_d   = mbr_q;
        we_d    = we_q;
        err_d   = err_q;
        tmr_clr = 1'b0;
        tmr_inc = 1'b0;

        if (control_signal[CS_TO_CLR]) begin
            err_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (control_signal[CS_MAR_MBR]) begin
                    mar_d = mbr_q[ADDR_W-1:0];
                end else if (control_signal[CS_MAR_PC]) begin
                    mar_d = pc_in;
                end
                if (control_signal[CS_MBR_ACC] && !rd_start) begin
                    mbr_d = acc_in;
                end
                if (rd_start || wr_start) begin
                    state_d = ACCESS;
                    we_d    = wr_start;
                    tmr_clr = 1'b1;
                end
            end
            ACCESS: begin
                if (mem_ack) begin
                    if (!we_q) begin
                        mbr_d = mem_rdata;
                    end
                    state_d = IDLE;
                    we_d    = 1'b0;
                end else if (tmr_tc) begin
                    state_d = IDLE;
                    we_d    = 1'b0;
                    err_d   = 1'b1;
                end else begin
                    tmr_inc = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; request/busy registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mar_q   <= '0;
            mbr_q   <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mar_q   <= mar_d;
            mbr_q   <= mbr_d;
            we_q    <= we_d;
            err_q   <= err_d;
            req_q   <= (state_d == ACCESS);
        end
    end

    assign mem_req     = req_q;
    assign busy        = req_q;
    assign mem_we      = we_q;
    assign mem_addr    = mar_q;
    assign mem_wdata   = mbr_q;
    assign MAR_out     = mar_q;
    assign MBR_out     = mbr_q;
    assign timeout_err = err_q;

endmodule

// File: tb/tb_mem_interface.sv
// Scoreboard bench for mem_interface: driver predicts transactions, monitor checks them.
module tb_mem_interface;

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 16;
    localparam int unsigned TO = 15;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [31:0]   control_signal;
    logic [AW-1:0] pc_in;
    logic [DW-1:0] acc_in;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [AW-1:0] MAR_out;
    logic [DW-1:0] MBR_out;
    logic          busy;
    logic          timeout_err;

    mem_interface #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .control_signal (control_signal),
        .pc_in          (pc_in),
        .acc_in         (acc_in),
        .mem_rdata      (mem_rdata),
        .mem_ack        (mem_ack),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .MAR_out        (MAR_out),
        .MBR_out        (MBR_out),
        .busy           (busy),
        .timeout_err    (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } req_t;

    typedef struct {
        logic [DW-1:0] mbr;
        logic [AW-1:0] mar;
        logic          err;
        int            lat;
    } done_t;

    int      total = 0;
    int      bad   = 0;
    req_t    req_q[$];
    done_t   done_q[$];
    logic [DW-1:0] mem [256];

    // Reference state of the stage as seen from the outside.
    logic [AW-1:0] m_mar;
    logic [DW-1:0] m_mbr;
    logic          m_err;
    bit            rst_seen = 1'b0;

    logic prev_req  = 1'b0;
    logic prev_busy = 1'b0;
    int   mon_lat   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One IDLE command; if it starts a transaction, also plays the memory for it.
    // w = wait cycles before ack (w >= TO means never ack); junk: 0 none, 1 [2]+[4], 2 random.
    task automatic run_cmd(input logic [31:0] cs, input int w_in, input int junk);
        bit            rd, wr;
        int            w, lat;
        logic [DW-1:0] rdat;
        req_t          r;
        done_t         d;
        control_signal = cs;
        if (cs[9]) m_err = 1'b0;
        rd = cs[4] && !cs[5];
        wr = cs[5];
        if (cs[3])      m_mar = m_mbr[AW-1:0];
        else if (cs[2]) m_mar = pc_in;
        if (cs[8] && !rd) m_mbr = acc_in;
        if (!(rd || wr)) begin
            @(posedge clk); #1;
            control_signal = '0;
            chk("idle_mar", 32'(MAR_out), 32'(m_mar));
            chk("idle_mbr", 32'(MBR_out), 32'(m_mbr));
            chk("idle_err", 32'(timeout_err), 32'(m_err));
            chk("idle_busy", 32'(busy), 32'd0);
            return;
        end
        w = (w_in < 0) ? int'($urandom_range(0, TO + 3)) : w_in;
        r.we = wr; r.addr = m_mar; r.wdata = m_mbr;
        req_q.push_back(r);
        rdat = mem[m_mar];
        if (w <= int'(TO) - 1) begin
            lat = w + 1;
            if (rd) m_mbr = rdat;
            else    mem[m_mar] = m_mbr;
        end else begin
            lat   = int'(TO);
            m_err = 1'b1;
        end
        d.mbr = m_mbr; d.mar = m_mar; d.err = m_err; d.lat = lat;
        done_q.push_back(d);
        @(posedge clk); #1;
        for (int k = 0; k < lat; k++) begin
            if (junk == 1)      control_signal = 32'h14;
            else if (junk == 2) control_signal = $urandom & 32'h13C;
            else                control_signal = '0;
            pc_in     = AW'($urandom);
            acc_in    = DW'($urandom);
            mem_ack   = (k == w);
            mem_rdata = (k == w) ? rdat : DW'($urandom);
            @(posedge clk); #1;
        end
        mem_ack        = 1'b0;
        control_signal = '0;
    endtask

    // Monitor: checks each request as it appears and each completion as busy falls.
    initial begin
        req_t  r;
        done_t d;
        forever begin
            @(negedge clk);
            if (rst_seen) begin
                rst_seen  = 1'b0;
                prev_req  = 1'b0;
                prev_busy = 1'b0;
                done_q.delete();
            end else begin
                if (mem_req && !prev_req) begin
                    if (req_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_req: got mem_req=1 expected no request");
                    end else begin
                        r = req_q.pop_front();
                        chk("req_we", 32'(mem_we), 32'(r.we));
                        chk("req_addr", 32'(mem_addr), 32'(r.addr));
                        chk("req_wdata", 32'(mem_wdata), 32'(r.wdata));
                    end
                    mon_lat = 0;
                end
                if (busy) mon_lat++;
                if (prev_busy && !busy) begin
                    if (done_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_done: got busy fall expected none");
                    end else begin
                        d = done_q.pop_front();
                        chk("done_mbr", 32'(MBR_out), 32'(d.mbr));
                        chk("done_mar", 32'(MAR_out), 32'(d.mar));
                        chk("done_err", 32'(timeout_err), 32'(d.err));
                        chk("done_busy_cycles", 32'(mon_lat), 32'(d.lat));
                        chk("done_we", 32'(mem_we), 32'd0);
                    end
                end
                prev_req  = mem_req;
                prev_busy = busy;
            end
        end
    end

    // Stimulus: directed scenarios followed by random transactions.
    initial begin
        req_t r;
        rst_n          = 1'b0;
        control_signal = '0;
        pc_in          = '0;
        acc_in         = '0;
        mem_rdata      = '0;
        mem_ack        = 1'b0;
        m_mar = '0; m_mbr = '0; m_err = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = DW'($urandom);
        mem[8'h34] = 16'h5A5A;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mar", 32'(MAR_out), 32'd0);
        chk("rst_mbr", 32'(MBR_out), 32'd0);
        chk("rst_err", 32'(timeout_err), 32'd0);

        // MAR priority: MBR low byte beats PC, read with two wait cycles.
        acc_in = 16'hAB34;
        run_cmd(32'h100, -1, 0);
        pc_in = 8'h12;
        run_cmd(32'h1C, 2, 0);

        // Write wins over read; MBR keeps the accumulator value.
        acc_in = 16'hBEEF;
        run_cmd(32'h100, -1, 0);
        run_cmd(32'h30, 1, 0);

        // Timeout then clear; then ack exactly on the timeout edge.
        run_cmd(32'h10, 99, 0);
        run_cmd(32'h200, -1, 0);
        run_cmd(32'h10, int'(TO) - 1, 0);

        // Commands while busy are ignored; next read right after busy falls.
        pc_in = 8'h77;
        run_cmd(32'h10, 3, 1);
        run_cmd(32'h10, 0, 0);

        // Reset in the middle of a read.
        control_signal = 32'h10;
        r.we = 1'b0; r.addr = m_mar; r.wdata = m_mbr;
        req_q.push_back(r);
        @(posedge clk); #1;
        control_signal = '0;
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        chk("midrst_req", 32'(mem_req), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_mar", 32'(MAR_out), 32'd0);
        chk("midrst_mbr", 32'(MBR_out), 32'd0);
        rst_seen = 1'b1;
        m_mar = '0; m_mbr = '0; m_err = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Random traffic.
        for (int i = 0; i < 80; i++) begin
            pc_in  = AW'($urandom);
            acc_in = DW'($urandom);
            run_cmd($urandom, -1, 2);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("req_queue_drained", 32'(req_q.size()), 32'd0);
        chk("done_queue_drained", 32'(done_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_interface.md
# mem_interface

Memory-access stage directly downstream of the program counter. It holds the memory address register (MAR) and the memory buffer register (MBR), and selects the MAR source from the PC output or the MBR low byte. It runs one read or write transaction at a time against the 256×16 main memory over a req/ack handshake, and returns read data in MBR, which feeds the PC (jump target) and the datapath.

## Interface
- `ADDR_W`, 8: address width; equals the PC width.
- `DATA_W`, 16: data width of MBR and memory.
- `TIMEOUT`, 15: maximum number of cycles `mem_req` waits for `mem_ack`; legal range 2..255.

- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `control_signal` in 32: control-unit word. Bits used here:
  - [2]: MAR←PC
  - [3]: MAR←MBR[7:0]
  - [4]: start read
  - [5]: start write
  - [8]: MBR←`acc_in`
  - [9]: clear `timeout_err`
  - All other bits are ignored. Bits [6] and [20] belong to the PC.
- `pc_in` in ADDR_W: PC address output.
- `acc_in` in DATA_W: accumulator value.
- `mem_rdata` in DATA_W: read data; valid when `mem_ack`=1.
- `mem_ack` in 1: memory completion. Sampled only while `mem_req`=1.
- `mem_req` out 1: transaction request.
- `mem_we` out 1: 1 = write, 0 = read; valid while `mem_req`=1.
- `mem_addr` out ADDR_W: equals MAR.
- `mem_wdata` out DATA_W: equals MBR.
- `MAR_out` out ADDR_W: MAR register.
- `MBR_out` out DATA_W: MBR register. Also drives the PC `MBR_in` input.
- `busy` out 1: a transaction is in flight. The control unit must stall while this is 1.
- `timeout_err` out 1: sticky; set when a transaction times out.

## Operation
- **States:**
  - IDLE: `mem_req`=0, `busy`=0.
  - ACCESS: `mem_req`=1, `busy`=1.
- **MAR load (IDLE only):**
  - [3] takes priority over [2]. This matches the PC rule where MBR-sourced loads win.
  - If neither bit is set, MAR holds.
- **MBR←acc_in:** takes effect in IDLE only, when [8]=1 and no read is started that cycle.
- **Start transaction:** in IDLE, [4] or [5] moves the FSM to ACCESS.
  - If both are set, the write wins.
  - `mem_we` is registered from the command.
- **Same-cycle MAR load and start:** the transaction uses the newly loaded MAR. Both registers update on the same edge, and `mem_addr` follows MAR.
- **Commands in ACCESS:** all command bits ([2]–[5], [8]) are ignored. Bit [9] is always honoured.
- **Completion:** in ACCESS with `mem_ack`=1, at that edge:
  - Read: MBR ← `mem_rdata`.
  - FSM returns to IDLE and `mem_we` returns to 0.
- **Timeout counter:**
  - Cleared on entry to ACCESS; increments each ACCESS cycle without an ack.
  - When the counter equals TIMEOUT−1 and there is no ack: go to IDLE, set `timeout_err`, leave MBR unchanged.
  - Ack on the same edge as the timeout wins: normal completion, no error.
- **timeout_err clear:** [9] clears it. A clear and a set on the same edge give set.
- **Reset:** asynchronous. All registers go to 0 immediately, including mid-transaction:
  - FSM = IDLE.
  - `mem_req`, `mem_we`, `busy`, `timeout_err` = 0.
  - MAR, MBR = 0.
  - The aborted transaction has no effect on MBR.

## Timing
- Command sampled at edge N. `mem_req`=1 and `busy`=1 are driven from just after edge N, through the cycle before edge N+1.
- `mem_ack` first sampled at edge N+1.
  - Zero-wait memory: ack at N+1, MBR valid and `busy`=0 after N+1.
  - Read latency is 1 + (wait cycles).
- A new command is accepted at the first edge where `busy` is 0 before that edge.
- Back-to-back transactions: minimum of 1 IDLE cycle between them.
- MAR/MBR loads from control bits take effect at the same edge they are sampled.
- Timeout fires at edge N+TIMEOUT when no ack has been seen.

## Structure
- Package `cpu_ctrl_pkg`:
  - Control-bit index constants: `CS_MAR_PC`=2, `CS_MAR_MBR`=3, `CS_MEM_RD`=4, `CS_MEM_WR`=5, `CS_PC_INC`=6, `CS_MBR_ACC`=8, `CS_TO_CLR`=9, `CS_PC_LOAD`=20.
  - FSM state enum {IDLE, ACCESS}.
  - The PC and control unit use the same package.
- One sub-module, `req_timer`: a clearable up-counter with a terminal-count output, parameterised by TIMEOUT.

## Test plan
- **Reset mid-read:** read issued, `mem_ack` held 0, `rst_n` pulsed low in cycle 3 → `mem_req`=0 immediately; MAR=0, MBR=0, `busy`=0.
- **MAR priority and read:** `pc_in`=8'h12, MBR=16'hAB34, [2]+[3]+[4] in one cycle, memory returns 16'h5A5A after 2 wait cycles → `mem_addr`=8'h34; ack sampled at N+3; MBR=16'h5A5A after N+3; `busy` high for 3 cycles.
- **Write wins:** `acc_in`=16'hBEEF; [8] in IDLE, then [4]+[5] → `mem_we`=1, `mem_wdata`=16'hBEEF; MBR unchanged after ack.
- **Timeout:** TIMEOUT=15, no ack → `mem_req` drops after edge N+15; `timeout_err`=1; MBR unchanged. Then [9] → `timeout_err`=0.
- **Ack at the timeout edge:** ack exactly at edge N+15 → read completes; `timeout_err` stays 0.
- **Commands while busy:** [2] and [4] asserted during ACCESS → MAR unchanged; exactly one `mem_req` pulse; next read accepted one cycle after `busy` falls.
